flow_sequencer: RTL

FLOW_SEQUENCER -- requirements
Module: flow_sequencer

---
 rtl/flow_seq_pkg.sv | 20 ++
 rtl/rr_arbiter2.sv | 28 ++
 rtl/flow_sequencer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/flow_seq_pkg.sv
// Shared types and defaults for the flow sequencer.
// State encodings are fixed because the state port drives a display.
package flow_seq_pkg;

   localparam int HOLD_CYCLES_DEF = 4;
   localparam int CNT_W_DEF = 8;

   typedef enum logic [2:0] {
      HOLD  = 3'd0,
      IDLE  = 3'd1,
      RUN   = 3'd2,
      DRAIN = 3'd3,
      FLUSH = 3'd4
   } flowStateT;

   function automatic logic isActive(flowStateT s);
      return (s == RUN) || (s == DRAIN);
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; req0 holds priority out of reset.
// Priority passes to the loser after every contested, advanced grant.
module rr_arbiter2 (
   input  logic clk,
   input  logic reset,
   input  logic req0,
   input  logic req1,
   input  logic advance,
   output logic gnt0,
   output logic gnt1
);

   logic prio1;

   always_comb begin
      gnt0 = req0 & (~req1 | ~prio1);
      gnt1 = req1 & (~req0 | prio1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prio1 <= 1'b0;
      end else if (advance && req0 && req1) begin
         prio1 <= ~prio1;
      end
   end

endmodule

// File: rtl/flow_sequencer.sv
// FIFO flow sequencer: HOLD/IDLE/RUN/DRAIN/FLUSH with arbitrated strobes.
// Define FLOW_SEQ_OVF_CNT_EN to build the dropped-write counter.
module flow_sequencer
   import flow_seq_pkg::*;
#(
   parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             flush_req,
   input  logic             wr_req,
   input  logic             rd_req,
   input  logic             fifo_empty,
   input  logic             fifo_full,
   input  logic             fifo_busy,
   input  logic             tx_done,
   output logic             fifo_we,
   output logic             fifo_re,
   output logic             fifo_rst,
   output logic             in_en,
   output logic             out_en,
   output logic             tx_en,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] ovf_cnt
);

   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

   flowStateT stateQ, stateD;
   logic [HW-1:0] holdCnt;
   logic wrEl, rdEl, gntW, gntR;

   assign wrEl = wr_req & (stateQ == RUN) & ~fifo_full & ~fifo_busy;
   assign rdEl = rd_req & isActive(stateQ) & ~fifo_empty & ~fifo_busy;

   rr_arbiter2 uArb (
      .clk     (clk),
      .reset   (reset),
      .req0    (wrEl),
      .req1    (rdEl),
      .advance (~fifo_rst),
      .gnt0    (gntW),
      .gnt1    (gntR)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         stateQ  <= HOLD;
         holdCnt <= '0;
      end else begin
         stateQ  <= stateD;
         holdCnt <= (stateQ == HOLD) ? holdCnt + HW'(1) : '0;
      end
   end

   always_comb begin
      stateD = stateQ;
      unique case (stateQ)
         HOLD:  if (holdCnt == HOLD_LAST) stateD = IDLE;
         IDLE: begin
            if (flush_req) stateD = FLUSH;
            else if (start) stateD = RUN;
         end
         RUN: begin
            if (flush_req) stateD = FLUSH;
            else if (start) stateD = DRAIN;
         end
         DRAIN: begin
            if (flush_req) stateD = FLUSH;
            else if (fifo_empty && tx_done && !(fifo_we || fifo_re))
               stateD = IDLE;
         end
         FLUSH: stateD = IDLE;
         default: stateD = HOLD;
      endcase
   end

   always_comb begin
      fifo_rst = (stateQ == HOLD) || (stateQ == FLUSH);
      fifo_we  = gntW & ~fifo_rst;
      fifo_re  = gntR & ~fifo_rst;
      state    = stateQ;
   end

   // Enables lag the state by one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         in_en  <= 1'b0;
         out_en <= 1'b0;
         tx_en  <= 1'b0;
      end else begin
         in_en  <= (stateQ == RUN);
         out_en <= isActive(stateQ);
         tx_en  <= isActive(stateQ);
      end
   end

`ifdef FLOW_SEQ_OVF_CNT_EN
   logic [CNT_W-1:0] ovfQ;
   logic drop;

   assign drop = wr_req & (stateQ == RUN) & fifo_full;

   // Entering FLUSH clears the count so it reads zero during FLUSH.
   always_ff @(posedge clk) begin
      if (reset) begin
         ovfQ <= '0;
      end else if (stateD == FLUSH) begin
         ovfQ <= '0;
      end else if (drop && (ovfQ != '1)) begin
         ovfQ <= ovfQ + 1'b1;
      end
   end

   assign ovf_cnt = ovfQ;
`else
   assign ovf_cnt = '0;
`endif

endmodule
